// File: rtl/riscv_writeback_if.sv
// Writeback-stage signal bundle: memory-stage handshake, load response,
// register-file write strobe, decode forwarding/stall and the retire counter.
interface riscv_writeback_if #(
    parameter int CNT_WIDTH = 64
);
    logic                 mem_valid_in;
    logic                 mem_ready_out;
    logic [4:0]           mem_rd_in;
    logic [1:0]           mem_wb_sel_in;
    logic [31:0]          mem_alu_in;
    logic [31:0]          mem_pc4_in;
    logic [2:0]           mem_funct3_in;
    logic [1:0]           mem_addr_lo_in;
    logic                 dmem_rvalid_in;
    logic [31:0]          dmem_rdata_in;
    logic [4:0]           rd_out;
    logic [31:0]          rd_val_out;
    logic                 we_out;
    logic [4:0]           ra_in;
    logic [4:0]           rb_in;
    logic [31:0]          ra_val_in;
    logic [31:0]          rb_val_in;
    logic [31:0]          ra_fwd_out;
    logic [31:0]          rb_fwd_out;
    logic                 stall_out;
    logic [CNT_WIDTH-1:0] instret_out;

    modport master (
        output mem_valid_in, mem_rd_in, mem_wb_sel_in, mem_alu_in, mem_pc4_in,
               mem_funct3_in, mem_addr_lo_in, dmem_rvalid_in, dmem_rdata_in,
               ra_in, rb_in, ra_val_in, rb_val_in,
        input  mem_ready_out, rd_out, rd_val_out, we_out, ra_fwd_out, rb_fwd_out,
               stall_out, instret_out
    );

    modport slave (
        input  mem_valid_in, mem_rd_in, mem_wb_sel_in, mem_alu_in, mem_pc4_in,
               mem_funct3_in, mem_addr_lo_in, dmem_rvalid_in, dmem_rdata_in,
               ra_in, rb_in, ra_val_in, rb_val_in,
        output mem_ready_out, rd_out, rd_val_out, we_out, ra_fwd_out, rb_fwd_out,
               stall_out, instret_out
    );
endinterface

// File: rtl/riscv_writeback.sv
// Final pipeline stage: retires instructions into register-file writes, waits on
// load data, forwards the in-flight write to decode and counts retirements.
// state     | meaning
// IDLE      | nothing retiring, ready to accept
// WAIT_LOAD | load accepted, waiting for dmem_rvalid_in
// COMMIT    | latched instruction retiring this cycle, ready to accept
module riscv_writeback #(
    parameter int CNT_WIDTH = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    riscv_writeback_if.slave bus
);
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

    state_t               state;
    logic [4:0]           rd_q;
    logic [1:0]           wb_sel_q;
    logic [2:0]           funct3_q;
    logic [1:0]           addr_lo_q;
    logic [31:0]          alu_q;
    logic [31:0]          pc4_q;
    logic [31:0]          load_q;
    logic                 we_q;
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 ready;
    logic                 accept;
    logic [31:0]          wb_val;

    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        // Halfword lane comes from addr_lo[1] only; a misaligned bit 0 is dropped.
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    format_load = {{24{b[7]}}, b};
            3'd1:    format_load = {{16{h[15]}}, h};
            3'd4:    format_load = {24'd0, b};
            3'd5:    format_load = {16'd0, h};
            default: format_load = w;
        endcase
    endfunction

    assign ready  = (state == IDLE) || (state == COMMIT);
    assign accept = bus.mem_valid_in && ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            rd_q      <= '0;
            wb_sel_q  <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            load_q    <= '0;
            we_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state)
                IDLE, COMMIT: begin
                    if (accept) begin
                        rd_q      <= bus.mem_rd_in;
                        wb_sel_q  <= bus.mem_wb_sel_in;
                        funct3_q  <= bus.mem_funct3_in;
                        addr_lo_q <= bus.mem_addr_lo_in;
                        alu_q     <= bus.mem_alu_in;
                        pc4_q     <= bus.mem_pc4_in;
                        if (bus.mem_wb_sel_in == SEL_LOAD) begin
                            state <= WAIT_LOAD;
                            we_q  <= 1'b0;
                        end else begin
                            state     <= COMMIT;
                            we_q      <= (bus.mem_rd_in != 5'd0) &&
                                         (bus.mem_wb_sel_in != SEL_NONE);
                            instret_q <= instret_q + CNT_ONE;
                        end
                    end else begin
                        state <= IDLE;
                        we_q  <= 1'b0;
                    end
                end
                WAIT_LOAD: begin
                    if (bus.dmem_rvalid_in) begin
                        load_q    <= format_load(funct3_q, addr_lo_q, bus.dmem_rdata_in);
                        state     <= COMMIT;
                        we_q      <= (rd_q != 5'd0);
                        instret_q <= instret_q + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wb_val = alu_q;
        if (wb_sel_q == SEL_LOAD) begin
            wb_val = load_q;
        end else if (wb_sel_q == SEL_PC4) begin
            wb_val = pc4_q;
        end
    end

    // Register file writes at the edge, so decode reads this cycle see stale data.
    always_comb begin
        bus.ra_fwd_out = bus.ra_val_in;
        bus.rb_fwd_out = bus.rb_val_in;
        if (we_q && (rd_q == bus.ra_in) && (bus.ra_in != 5'd0)) begin
            bus.ra_fwd_out = wb_val;
        end
        if (we_q && (rd_q == bus.rb_in) && (bus.rb_in != 5'd0)) begin
            bus.rb_fwd_out = wb_val;
        end
    end

    assign bus.stall_out = (state == WAIT_LOAD) && (rd_q != 5'd0) &&
                           ((bus.ra_in == rd_q) || (bus.rb_in == rd_q));

    assign bus.mem_ready_out = ready;
    assign bus.rd_out        = rd_q;
    assign bus.rd_val_out    = wb_val;
    assign bus.we_out        = we_q;
    assign bus.instret_out   = instret_q;
endmodule

// File: tb/tb_riscv_writeback.sv
// Self-checking bench for riscv_writeback: vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_riscv_writeback;
    localparam int CW = 4;
    localparam logic [1:0] ALU  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PC4  = 2'd2;
    localparam logic [1:0] NONE = 2'd3;

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        int          lat;
        logic        we;
        logic [31:0] val;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    riscv_writeback_if #(.CNT_WIDTH(CW)) bus ();
    riscv_writeback #(.CNT_WIDTH(CW)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk(name, 64'(bus.instret_out), 64'(exp_cnt % (1 << CW)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.mem_valid_in   = 1'b0;
        bus.mem_rd_in      = '0;
        bus.mem_wb_sel_in  = '0;
        bus.mem_alu_in     = '0;
        bus.mem_pc4_in     = '0;
        bus.mem_funct3_in  = '0;
        bus.mem_addr_lo_in = '0;
        bus.dmem_rvalid_in = 1'b0;
        bus.dmem_rdata_in  = '0;
        bus.ra_in          = '0;
        bus.rb_in          = '0;
        bus.ra_val_in      = '0;
        bus.rb_val_in      = '0;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] pc4);
        bus.mem_valid_in   = 1'b1;
        bus.mem_rd_in      = rd;
        bus.mem_wb_sel_in  = sel;
        bus.mem_funct3_in  = f3;
        bus.mem_addr_lo_in = lo;
        bus.mem_alu_in     = alu;
        bus.mem_pc4_in     = pc4;
    endtask

    // Load result from the ISA definition: pick the lane, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    initial begin
        bit          waiting;
        logic [4:0]  p_rd;
        logic [2:0]  p_f3;
        logic [1:0]  p_lo;
        logic        m_we;
        logic [4:0]  m_rd;
        logic [31:0] m_val;

        vecs[0]  = '{5'd5,  ALU,  3'd0, 2'd0, 32'h0000_1234, 32'h0,   32'h0,         1, 1'b1, 32'h0000_1234};
        vecs[1]  = '{5'd3,  LOAD, 3'd0, 2'd3, 32'h0,         32'h0,   32'h80FF_FF00, 4, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{5'd4,  LOAD, 3'd5, 2'd2, 32'h0,         32'h0,   32'h80FF_FF00, 2, 1'b1, 32'h0000_80FF};
        vecs[3]  = '{5'd6,  LOAD, 3'd1, 2'd1, 32'h0,         32'h0,   32'h80FF_FF00, 1, 1'b1, 32'hFFFF_FF00};
        vecs[4]  = '{5'd9,  PC4,  3'd0, 2'd0, 32'h5555_0000, 32'h100, 32'h0,         1, 1'b1, 32'h0000_0100};
        vecs[5]  = '{5'd0,  ALU,  3'd0, 2'd0, 32'h0000_0777, 32'h0,   32'h0,         1, 1'b0, 32'h0};
        vecs[6]  = '{5'd8,  NONE, 3'd0, 2'd0, 32'h0000_0888, 32'h0,   32'h0,         1, 1'b0, 32'h0};
        vecs[7]  = '{5'd10, LOAD, 3'd2, 2'd1, 32'h0,         32'h0,   32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF};
        vecs[8]  = '{5'd11, LOAD, 3'd4, 2'd1, 32'h0,         32'h0,   32'h1234_8A56, 2, 1'b1, 32'h0000_008A};
        vecs[9]  = '{5'd12, LOAD, 3'd0, 2'd0, 32'h0,         32'h0,   32'h0000_007F, 1, 1'b1, 32'h0000_007F};
        vecs[10] = '{5'd13, LOAD, 3'd3, 2'd2, 32'h0,         32'h0,   32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D};
        vecs[11] = '{5'd14, LOAD, 3'd1, 2'd3, 32'h0,         32'h0,   32'h9ABC_1234, 1, 1'b1, 32'hFFFF_9ABC};
        vecs[12] = '{5'd0,  LOAD, 3'd2, 2'd0, 32'h0,         32'h0,   32'h1111_2222, 2, 1'b0, 32'h0};

        idle_in();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_we", bus.we_out, 1'b0);
        chk("rst_rd", bus.rd_out, 5'd0);
        chk("rst_val", bus.rd_val_out, 32'h0);
        chk("rst_instret", bus.instret_out, 64'h0);
        chk("rst_ready", bus.mem_ready_out, 1'b1);
        chk("rst_stall", bus.stall_out, 1'b0);
        #9 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rd, vecs[i].sel, vecs[i].f3, vecs[i].lo, vecs[i].alu, vecs[i].pc4);
            #1 chk("tbl_ready_accept", bus.mem_ready_out, 1'b1);
            tick();
            bus.mem_valid_in = 1'b0;
            if (vecs[i].sel == LOAD) begin
                for (int k = 0; k < vecs[i].lat - 1; k++) begin
                    chk("tbl_ready_wait", bus.mem_ready_out, 1'b0);
                    chk("tbl_we_wait", bus.we_out, 1'b0);
                    tick();
                end
                bus.dmem_rvalid_in = 1'b1;
                bus.dmem_rdata_in  = vecs[i].rdata;
                tick();
                bus.dmem_rvalid_in = 1'b0;
            end
            exp_cnt++;
            chk("tbl_we", bus.we_out, vecs[i].we);
            if (vecs[i].we) begin
                chk("tbl_rd", bus.rd_out, vecs[i].rd);
                chk("tbl_val", bus.rd_val_out, vecs[i].val);
            end
            chk_cnt("tbl_instret");
            tick();
            chk("tbl_idle_we", bus.we_out, 1'b0);
        end

        // ALU write forwarded to decode in the commit cycle only.
        drive(5'd5, ALU, 3'd0, 2'd0, 32'h0000_1234, 32'h0);
        tick();
        bus.mem_valid_in = 1'b0;
        exp_cnt++;
        bus.ra_in = 5'd5; bus.ra_val_in = 32'hAAAA_AAAA;
        bus.rb_in = 5'd6; bus.rb_val_in = 32'hBBBB_BBBB;
        #1;
        chk("fwd_ra_hit", bus.ra_fwd_out, 32'h0000_1234);
        chk("fwd_rb_miss", bus.rb_fwd_out, 32'hBBBB_BBBB);
        bus.rb_in = 5'd5;
        #1 chk("fwd_rb_hit", bus.rb_fwd_out, 32'h0000_1234);
        tick();
        chk("fwd_ra_after", bus.ra_fwd_out, 32'hAAAA_AAAA);
        idle_in();

        // Load-use hazard, then a load to x0 which must never stall or write.
        drive(5'd7, LOAD, 3'd2, 2'd0, 32'h0, 32'h0);
        tick();
        bus.mem_valid_in = 1'b0;
        bus.ra_in = 5'd7;
        #1 chk("haz_stall_ra", bus.stall_out, 1'b1);
        bus.ra_in = 5'd3; bus.rb_in = 5'd7;
        #1 chk("haz_stall_rb", bus.stall_out, 1'b1);
        bus.rb_in = 5'd2;
        #1 chk("haz_no_stall", bus.stall_out, 1'b0);
        bus.dmem_rvalid_in = 1'b1; bus.dmem_rdata_in = 32'h0000_0055;
        tick();
        bus.dmem_rvalid_in = 1'b0;
        exp_cnt++;
        chk("haz_we", bus.we_out, 1'b1);
        chk("haz_rd", bus.rd_out, 5'd7);
        bus.ra_in = 5'd7;
        #1 chk("haz_fwd", bus.ra_fwd_out, 32'h0000_0055);
        chk("haz_stall_commit", bus.stall_out, 1'b0);
        tick();
        idle_in();
        drive(5'd0, LOAD, 3'd2, 2'd0, 32'h0, 32'h0);
        tick();
        bus.mem_valid_in = 1'b0;
        #1 chk("x0_stall", bus.stall_out, 1'b0);
        bus.dmem_rvalid_in = 1'b1; bus.dmem_rdata_in = 32'h1234_5678;
        tick();
        bus.dmem_rvalid_in = 1'b0;
        exp_cnt++;
        chk("x0_we", bus.we_out, 1'b0);
        chk_cnt("x0_instret");
        tick();

        // Three back-to-back ALU instructions.
        for (int j = 1; j <= 3; j++) begin
            drive(5'(j), ALU, 3'd0, 2'd0, 32'(11 * j), 32'h0);
            #1 chk("b2b_ready", bus.mem_ready_out, 1'b1);
            tick();
            exp_cnt++;
            chk("b2b_we", bus.we_out, 1'b1);
            chk("b2b_rd", bus.rd_out, 5'(j));
            chk("b2b_val", bus.rd_val_out, 32'(11 * j));
        end
        bus.mem_valid_in = 1'b0;
        chk_cnt("b2b_instret");
        tick();
        chk("b2b_end_we", bus.we_out, 1'b0);

        // Async reset in the middle of a pending load.
        drive(5'd15, LOAD, 3'd2, 2'd0, 32'h0, 32'h0);
        tick();
        bus.mem_valid_in = 1'b0;
        tick();
        tick();
        chk("rwait_ready", bus.mem_ready_out, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rwait_we", bus.we_out, 1'b0);
        chk("rwait_rd", bus.rd_out, 5'd0);
        chk("rwait_val", bus.rd_val_out, 32'h0);
        chk("rwait_instret", bus.instret_out, 64'h0);
        chk("rwait_ready_rst", bus.mem_ready_out, 1'b1);
        #2 rst_n = 1'b1;
        bus.dmem_rvalid_in = 1'b1; bus.dmem_rdata_in = 32'hFFFF_FFFF;
        tick();
        chk("stray_we1", bus.we_out, 1'b0);
        tick();
        chk("stray_we2", bus.we_out, 1'b0);
        chk_cnt("stray_instret");
        bus.dmem_rvalid_in = 1'b0;

        // Counter wrap at 2^CW retirements.
        for (int j = 0; j < 16; j++) begin
            drive(5'(j + 1), ALU, 3'd0, 2'd0, 32'(j), 32'h0);
            tick();
            exp_cnt++;
            if (j == 14) chk_cnt("wrap_15");
        end
        bus.mem_valid_in = 1'b0;
        chk("wrap_0", bus.instret_out, 64'h0);
        tick();

        // Randomized run against the transaction-level model.
        waiting = 1'b0;
        m_we = 1'b0; m_rd = '0; m_val = '0;
        p_rd = '0; p_f3 = '0; p_lo = '0;
        for (int c = 0; c < 600; c++) begin
            bus.mem_valid_in   = ($urandom_range(0, 9) < 7);
            bus.mem_rd_in      = 5'($urandom_range(0, 7));
            bus.mem_wb_sel_in  = 2'($urandom_range(0, 3));
            bus.mem_funct3_in  = 3'($urandom_range(0, 7));
            bus.mem_addr_lo_in = 2'($urandom_range(0, 3));
            bus.mem_alu_in     = $urandom;
            bus.mem_pc4_in     = $urandom;
            bus.dmem_rvalid_in = ($urandom_range(0, 9) < 4);
            bus.dmem_rdata_in  = $urandom;
            bus.ra_in          = 5'($urandom_range(0, 7));
            bus.rb_in          = 5'($urandom_range(0, 7));
            bus.ra_val_in      = $urandom;
            bus.rb_val_in      = $urandom;
            #1;
            chk("rnd_ready", bus.mem_ready_out, !waiting);
            chk("rnd_stall", bus.stall_out,
                waiting && p_rd != 0 && (bus.ra_in == p_rd || bus.rb_in == p_rd));
            chk("rnd_fwd_a", bus.ra_fwd_out,
                (m_we && m_rd == bus.ra_in && bus.ra_in != 0) ? m_val : bus.ra_val_in);
            chk("rnd_fwd_b", bus.rb_fwd_out,
                (m_we && m_rd == bus.rb_in && bus.rb_in != 0) ? m_val : bus.rb_val_in);
            m_we = 1'b0;
            if (waiting) begin
                if (bus.dmem_rvalid_in) begin
                    waiting = 1'b0;
                    m_we  = (p_rd != 0);
                    m_rd  = p_rd;
                    m_val = ref_load(p_f3, p_lo, bus.dmem_rdata_in);
                    exp_cnt++;
                end
            end else if (bus.mem_valid_in) begin
                if (bus.mem_wb_sel_in == LOAD) begin
                    waiting = 1'b1;
                    p_rd = bus.mem_rd_in;
                    p_f3 = bus.mem_funct3_in;
                    p_lo = bus.mem_addr_lo_in;
                end else begin
                    m_we  = (bus.mem_rd_in != 0) && (bus.mem_wb_sel_in != NONE);
                    m_rd  = bus.mem_rd_in;
                    m_val = (bus.mem_wb_sel_in == PC4) ? bus.mem_pc4_in : bus.mem_alu_in;
                    exp_cnt++;
                end
            end
            tick();
            chk("rnd_we", bus.we_out, m_we);
            if (m_we) begin
                chk("rnd_rd", bus.rd_out, m_rd);
                chk("rnd_val", bus.rd_val_out, m_val);
            end
            chk_cnt("rnd_instret");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
- Writer-side partner of the core register file: final pipeline stage that turns retiring instructions into register-file write strobes (rd, value, we).
- Waits for variable-latency data-memory load responses, then sign/zero-extends and aligns them.
- Forwards the value being written this cycle to decode-stage operand reads, since the register file updates only at the clock edge.
- Counts retired instructions.

Parameters:
CNT_WIDTH, 64, width of retired-instruction counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
mem_valid_in  input  1  memory stage presents an instruction
mem_ready_out  output  1  writeback can accept this cycle
mem_rd_in  input  5  destination register
mem_wb_sel_in  input  2  source: 0=ALU, 1=LOAD, 2=PC+4, 3=no write
mem_alu_in  input  32  ALU result
mem_pc4_in  input  32  PC+4 (link value)
mem_funct3_in  input  3  load type (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU)
mem_addr_lo_in  input  2  load address bits [1:0]
dmem_rvalid_in  input  1  load data valid
dmem_rdata_in  input  32  raw aligned load word
rd_out  output  5  register file write index
rd_val_out  output  32  register file write data
we_out  output  1  register file write enable
ra_in, rb_in  input  5 each  decode-stage read indices
ra_val_in, rb_val_in  input  32 each  register file read data
ra_fwd_out, rb_fwd_out  output  32 each  forwarded operands
stall_out  output  1  decode must stall (operand pending on load)
instret_out  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (rst_in low, async): state IDLE, we_out=0, rd_out=0, rd_val_out=0, instret_out=0, latched fields cleared. Reset mid-WAIT_LOAD abandons the load; a later dmem_rvalid_in is ignored.
- States: IDLE, WAIT_LOAD, COMMIT.
- mem_ready_out = (state==IDLE) || (state==COMMIT). Accept = mem_valid_in && mem_ready_out.
- On accept, latch rd, wb_sel, funct3, addr_lo, ALU and PC+4 values.
  - wb_sel LOAD: go to WAIT_LOAD.
  - Otherwise: go to COMMIT.
- In COMMIT with no accept: go to IDLE. Back-to-back non-loads give one commit per cycle.
- WAIT_LOAD: on dmem_rvalid_in, format the data into rd_val_out and go to COMMIT. Otherwise hold. dmem_rvalid_in outside WAIT_LOAD is ignored.
- Load formatting:
  - LB/LBU: byte addr_lo.
  - LH/LHU: halfword addr_lo[1]; addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and funct3 3, 6, 7: full word.
- Value select in COMMIT: ALU → mem_alu_in (latched); PC+4 → pc4 (latched); LOAD → formatted data.
- Latency: non-load accepted cycle N → we_out high in cycle N+1. Load rvalid in cycle M → we_out high in M+1.
- we_out is high exactly during COMMIT, and only if rd≠0 and wb_sel≠3. rd_out and rd_val_out are valid when we_out is high.
- instret_out increments by 1 on entering COMMIT, including rd=0 and wb_sel=3 cases.
- Forwarding (combinational): ra_fwd_out = rd_val_out if we_out && rd_out==ra_in && ra_in≠0, else ra_val_in. rb_fwd_out is the same with rb_in/rb_val_in.
- stall_out (combinational): high when state==WAIT_LOAD && latched rd≠0 && (ra_in==rd || rb_in==rd).

Test Plan:
- ALU write: accept rd=5, ALU=0x1234 in cycle 0 → cycle 1 we_out=1, rd_out=5, rd_val_out=0x1234, instret=1; ra_in=5 gives ra_fwd_out=0x1234.
- Loads: LB addr_lo=3, rdata=0x80FF_FF00 → 0xFFFF_FF80. LHU addr_lo=2 → 0x0000_80FF. LH addr_lo=1 → 0xFFFF_FF00 (low half). rvalid 4 cycles after accept → we_out one cycle after rvalid; mem_ready_out low meanwhile.
- Hazard: load to rd=7 pending, ra_in=7 → stall_out=1; same with ra_in=0 for a load to rd=0 → stall_out=0, we_out never asserts, instret still increments.
- Back-to-back: three ALU instructions on consecutive cycles → three consecutive we_out pulses with matching rd/val, mem_ready_out stays high, instret=3.
- Async reset asserted mid-WAIT_LOAD (no clock edge) → outputs 0 immediately. After release, a stray dmem_rvalid_in produces no write.
- Counter wrap with CNT_WIDTH=4: 16 retirements → instret_out=0.
